// File: rtl/rr_grant_datapath.sv
// rr_grant_datapath: steers the granted requester's beat into a small
// source-tagged FIFO that feeds one shared valid/ready output channel.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   grant        one-hot grant from the arbiter (0 = idle)
//   src_valid    per-requester beat valid
//   src_data     requester i data at [i*DW +: DW]
//   src_ready    per-requester accept (from grant and occupancy only)
//   out_valid    FIFO head valid
//   out_data     FIFO head data (0 while empty)
//   out_src      FIFO head source index (0 while empty)
//   out_ready    sink accept
//   beat_cnt     saturating accepted-beat count, source i at [i*CNT_W +: CNT_W]
//   err_grant    sticky multi-hot grant flag
module rr_grant_datapath #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         grant,
    input  logic [3:0]         src_valid,
    input  logic [4*DW-1:0]    src_data,
    output logic [3:0]         src_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready,
    output logic [4*CNT_W-1:0] beat_cnt,
    output logic               err_grant
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + 2;

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] L_CMAX = '1;

    // Storage and control state
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic [CNT_W-1:0] r_cnt [4];
    logic             r_err;

    // Combinational helpers
    logic             w_grant_ok;
    logic             w_full;
    logic             w_empty;
    logic [3:0]       w_acc;
    logic             w_enq;
    logic             w_deq;
    logic [1:0]       w_enq_idx;
    logic [DW-1:0]    w_enq_data;
    logic [EW-1:0]    w_head;

    // Zero or one bit set: clearing the lowest set bit leaves nothing.
    assign w_grant_ok = ((grant & (grant - 4'd1)) == 4'd0);

    assign w_full  = (r_occ == L_FULL);
    assign w_empty = (r_occ == '0);

    // Full blocks acceptance even if the sink pops this cycle, which keeps
    // out_ready off the src_ready path.
    assign src_ready = grant & {4{w_grant_ok & ~w_full & ~rst}};

    assign w_acc = src_valid & src_ready;
    assign w_enq = |w_acc;
    assign w_deq = ~w_empty & out_ready;

    // w_acc is at most one-hot, so a simple scan encodes it.
    always_comb begin
        w_enq_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_acc[i]) begin
                w_enq_idx = 2'(i);
            end
        end
    end

    assign w_enq_data = src_data[w_enq_idx*DW +: DW];

    // FIFO storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {w_enq_idx, w_enq_data};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Per-source saturating beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc[i] && r_cnt[i] != L_CMAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!w_grant_ok) begin
            r_err <= 1'b1;
        end
    end

    // Output channel: head is forced to zero while empty so the
    // post-reset values are defined without clearing the storage array.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : w_head[DW-1:0];
    assign out_src   = w_empty ? 2'd0 : w_head[EW-1:DW];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_cnt
            assign beat_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

    assign err_grant = r_err;

endmodule

// File: tb/tb_rr_grant_datapath.sv
// tb_rr_grant_datapath: randomized and directed checks of rr_grant_datapath
// against a queue-based reference model.
module tb_rr_grant_datapath;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        grant;
    logic [3:0]        src_valid;
    logic [4*DW-1:0]   src_data;
    logic [3:0]        src_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              out_ready;
    logic [4*CW-1:0]   beat_cnt;
    logic              err_grant;

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of {src, data}, counts, sticky error.
    logic [DW+1:0] q[$];
    int            m_cnt [4];
    bit            m_err;

    rr_grant_datapath #(
        .DW(DW),
        .DEPTH(DEPTH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .grant(grant),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready),
        .beat_cnt(beat_cnt),
        .err_grant(err_grant)
    );

    always #5 clk = ~clk;

    function automatic bit onehot0(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += v[i];
        return n <= 1;
    endfunction

    function automatic logic [3:0] exp_ready();
        if (rst) return 4'b0000;
        if (onehot0(grant) && q.size() < DEPTH) return grant;
        return 4'b0000;
    endfunction

    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        logic [DW+1:0] e;
        if (q.size() == 0) return '0;
        e = q[0];
        return e[DW-1:0];
    endfunction

    function automatic logic [1:0] exp_src();
        logic [DW+1:0] e;
        if (q.size() == 0) return 2'd0;
        e = q[0];
        return e[DW+1:DW];
    endfunction

    task automatic drive(input logic [3:0] g, input logic [3:0] v,
                         input logic [4*DW-1:0] d, input logic r);
        grant     = g;
        src_valid = v;
        src_data  = d;
        out_ready = r;
        #1;
    endtask

    // Advance one clock and apply the model's rules for that edge.
    task automatic tick();
        int  sz;
        bit  ok;
        bit  enq;
        bit  deq;
        int  idx;
        logic [DW-1:0] d;
        sz  = q.size();
        ok  = onehot0(grant);
        enq = 0;
        idx = 0;
        if (!rst && ok && sz < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i] && src_valid[i]) begin
                    enq = 1;
                    idx = i;
                end
            end
        end
        deq = (sz > 0) && out_ready;
        d   = src_data[idx*DW +: DW];
        @(posedge clk);
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            if (deq) void'(q.pop_front());
            if (enq) begin
                q.push_back({2'(idx), d});
                if (m_cnt[idx] < CMAX) m_cnt[idx]++;
            end
            if (!ok) m_err = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(4'($urandom), 4'($urandom), {$urandom}, 1'($urandom));
            total++;
            if (src_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_ready got=%b want=0000", src_ready);
            end
            tick();
        end
        rst = 1'b0;
        drive(4'b0000, 4'b0000, '0, 1'b0);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
            bad++;
            $display("FAIL reset_out got=%b/%h/%0d want=0/00/0",
                     out_valid, out_data, out_src);
        end
        total++;
        if (beat_cnt !== '0 || err_grant !== 1'b0) begin
            bad++;
            $display("FAIL reset_state cnt=%h err=%b want=0/0",
                     beat_cnt, err_grant);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(4'b0001, 4'b0001, {24'h0, vals[c]}, 1'b1);
            else       drive(4'b0001, 4'b0000, '0, 1'b1);
            total++;
            if (out_valid !== exp_valid() || out_data !== exp_data()
                || out_src !== exp_src()) begin
                bad++;
                $display("FAIL basic_out c=%0d got=%b/%h/%0d want=%b/%h/%0d",
                         c, out_valid, out_data, out_src,
                         exp_valid(), exp_data(), exp_src());
            end
            if (c >= 1 && c <= 3) begin
                total++;
                if (out_data !== vals[c-1] || out_src !== 2'd0) begin
                    bad++;
                    $display("FAIL basic_seq c=%0d got=%h want=%h",
                             c, out_data, vals[c-1]);
                end
            end
            tick();
        end
        total++;
        if (beat_cnt[0 +: CW] !== 4'd3) begin
            bad++;
            $display("FAIL basic_cnt got=%0d want=3", beat_cnt[0 +: CW]);
        end
    endtask

    task automatic test_fill();
        logic [7:0] d;
        for (int c = 0; c < 6; c++) begin
            d = 8'h40 + 8'(c);
            drive(4'b0100, 4'b0100, {8'h0, d, 16'h0}, 1'b0);
            total++;
            if (src_ready !== exp_ready()) begin
                bad++;
                $display("FAIL fill_ready c=%0d got=%b want=%b",
                         c, src_ready, exp_ready());
            end
            tick();
        end
        total++;
        if (src_ready !== 4'b0000 || q.size() != DEPTH) begin
            bad++;
            $display("FAIL fill_full got=%b want=0000", src_ready);
        end
        for (int c = 0; c < 6; c++) begin
            drive(4'b0100, 4'b0000, '0, 1'b1);
            total++;
            if (src_ready !== exp_ready() || out_valid !== exp_valid()
                || out_data !== exp_data() || out_src !== exp_src()) begin
                bad++;
                $display("FAIL drain c=%0d got=%b/%b/%h want=%b/%b/%h", c,
                         src_ready, out_valid, out_data,
                         exp_ready(), exp_valid(), exp_data());
            end
            if (c == 1) begin
                total++;
                if (src_ready !== 4'b0100) begin
                    bad++;
                    $display("FAIL drain_reopen got=%b want=0100", src_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_full_simul();
        for (int c = 0; c < 4; c++) begin
            drive(4'b0001, 4'b0001, {24'h0, 8'hA0 + 8'(c)}, 1'b0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            unique case (c)
                0: drive(4'b0001, 4'b0001, {24'h0, 8'hB0}, 1'b1);
                1: drive(4'b0001, 4'b0001, {24'h0, 8'hB1}, 1'b1);
                2: drive(4'b0001, 4'b0001, {24'h0, 8'hB2}, 1'b0);
                default: drive(4'b0001, 4'b0001, {24'h0, 8'hB3}, 1'b0);
            endcase
            total++;
            if (src_ready !== exp_ready() || out_data !== exp_data()) begin
                bad++;
                $display("FAIL full_simul c=%0d got=%b/%h want=%b/%h", c,
                         src_ready, out_data, exp_ready(), exp_data());
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 4'b0000, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_multihot();
        drive(4'b0011, 4'b1111, {$urandom}, 1'b0);
        total++;
        if (src_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mh_ready got=%b want=0000", src_ready);
        end
        total++;
        if (err_grant !== 1'b0) begin
            bad++;
            $display("FAIL mh_err_early got=%b want=0", err_grant);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 4'b0000, '0, 1'b1);
            total++;
            if (err_grant !== m_err || out_valid !== exp_valid()) begin
                bad++;
                $display("FAIL mh_hold c=%0d got=%b/%b want=%b/%b", c,
                         err_grant, out_valid, m_err, exp_valid());
            end
            tick();
        end
        rst = 1'b1;
        drive(4'b0000, 4'b0000, '0, 1'b0);
        tick();
        rst = 1'b0;
        drive(4'b0000, 4'b0000, '0, 1'b0);
        total++;
        if (err_grant !== 1'b0) begin
            bad++;
            $display("FAIL mh_clear got=%b want=0", err_grant);
        end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 20; c++) begin
            drive(4'b1000, 4'b1000, {8'(c), 24'h0}, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (beat_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
                bad++;
                $display("FAIL sat_cnt%0d got=%0d want=%0d",
                         i, beat_cnt[i*CW +: CW], m_cnt[i]);
            end
        end
        total++;
        if (beat_cnt[3*CW +: CW] !== 4'd15) begin
            bad++;
            $display("FAIL sat_max got=%0d want=15", beat_cnt[3*CW +: CW]);
        end
        for (int c = 0; c < 12; c++) begin
            drive((c % 2 == 0) ? 4'b0001 : 4'b0010, 4'b0011,
                  {16'h0, 8'h20 + 8'(c), 8'h10 + 8'(c)}, 1'(c % 3 != 0));
            total++;
            if (out_valid !== exp_valid() || out_src !== exp_src()
                || out_data !== exp_data()) begin
                bad++;
                $display("FAIL interleave c=%0d got=%b/%0d/%h want=%b/%0d/%h",
                         c, out_valid, out_src, out_data,
                         exp_valid(), exp_src(), exp_data());
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      g = 4'b0000;
            else if (r == 1) g = 4'($urandom);
            else             g = 4'b0001 << $urandom_range(0, 3);
            rst = ($urandom_range(0, 59) == 0);
            drive(g, 4'($urandom), {$urandom}, 1'($urandom));
            total++;
            if (src_ready !== exp_ready() || out_valid !== exp_valid()
                || out_data !== exp_data() || out_src !== exp_src()) begin
                bad++;
                $display("FAIL rand_out c=%0d got=%b/%b/%h/%0d want=%b/%b/%h/%0d",
                         c, src_ready, out_valid, out_data, out_src,
                         exp_ready(), exp_valid(), exp_data(), exp_src());
            end
            total++;
            if (err_grant !== m_err
                || beat_cnt !== {CW'(m_cnt[3]), CW'(m_cnt[2]),
                                 CW'(m_cnt[1]), CW'(m_cnt[0])}) begin
                bad++;
                $display("FAIL rand_state c=%0d err=%b/%b cnt=%h", c,
                         err_grant, m_err, beat_cnt);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        m_err = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        rst       = 1'b1;
        grant     = '0;
        src_valid = '0;
        src_data  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill();
        test_full_simul();
        test_multihot();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
